// File: rtl/pgm_sequencer.sv
// ============================================================================
// Module  : pgm_sequencer
// Purpose : Program counter with a return-address stack for branch, call and
//           ret. Defining PGM_SEQ_STKERR_EN adds the sticky stkErr output.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module pgm_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             branch,
  input  logic                             call,
  input  logic                             ret,
  input  logic [ADDR_W-1:0]                pcIn,
  output logic [ADDR_W-1:0]                pcOut,
  output logic [$clog2(STACK_DEPTH):0]     stkDepth,
  output logic                             stkFull,
  output logic                             stkEmpty
`ifdef PGM_SEQ_STKERR_EN
  ,output logic                            stkErr
`endif
);

  localparam int                  c_IDX_W      = $clog2(STACK_DEPTH);
  localparam int                  c_PTR_W      = c_IDX_W + 1;
  localparam logic [c_PTR_W-1:0]  c_FULL_DEPTH = c_PTR_W'(STACK_DEPTH);
  localparam logic [c_PTR_W-1:0]  c_PTR_ONE    = c_PTR_W'(1);
  localparam logic [ADDR_W-1:0]   c_ADDR_ONE   = ADDR_W'(1);

  // Declaration initialisers give the pre-reset power-up value.
  logic [ADDR_W-1:0]  r_pc    = RESET_ADDR;
  logic [c_PTR_W-1:0] r_depth = '0;
  logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];

  logic [ADDR_W-1:0]  w_pcInc;
  logic [c_PTR_W-1:0] w_depthDec;
  logic [c_IDX_W-1:0] w_wrIdx;
  logic [c_IDX_W-1:0] w_rdIdx;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_errSet;
  logic [ADDR_W-1:0]  w_pcNext;
  logic [c_PTR_W-1:0] w_depthNext;

  assign w_pcInc    = r_pc + c_ADDR_ONE;
  assign w_depthDec = r_depth - c_PTR_ONE;
  assign w_wrIdx    = r_depth[c_IDX_W-1:0];
  assign w_rdIdx    = w_depthDec[c_IDX_W-1:0];
  assign w_full     = (r_depth == c_FULL_DEPTH);
  assign w_empty    = (r_depth == '0);

  // Priority below stall: ret > call > branch > increment.
  always_comb begin
    w_pcNext    = w_pcInc;
    w_depthNext = r_depth;
    w_push      = 1'b0;
    w_errSet    = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (!w_empty) begin
          w_pcNext    = r_stack[w_rdIdx];
          w_depthNext = w_depthDec;
        end else begin
          w_errSet = 1'b1;
        end
      end else if (call) begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_pcNext    = pcIn;
          w_depthNext = r_depth + c_PTR_ONE;
        end else begin
          w_errSet = 1'b1;
        end
      end else if (branch) begin
        w_pcNext = pcIn;
      end
    end else begin
      w_pcNext = r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_ADDR;
      r_depth <= '0;
    end else begin
      r_pc    <= w_pcNext;
      r_depth <= w_depthNext;
    end
  end

  // Stack storage is never cleared; depth alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_stack[w_wrIdx] <= w_pcInc;
    end
  end

  assign pcOut    = r_pc;
  assign stkDepth = r_depth;
  assign stkFull  = w_full;
  assign stkEmpty = w_empty;

`ifdef PGM_SEQ_STKERR_EN
  logic r_err = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_errSet) begin
      r_err <= 1'b1;
    end
  end

  assign stkErr = r_err;
`else
  logic w_errUnused;
  assign w_errUnused = w_errSet;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pgm_sequencer.sv
// ============================================================================
// Module  : tb_pgm_sequencer
// Purpose : Self-checking bench for pgm_sequencer: directed scenarios plus
//           randomized traffic compared against a queue-based reference model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pgm_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0, stall = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0;
  logic [7:0] pcIn = '0;
  logic [7:0] pcOut;
  logic [2:0] stkDepth;
  logic       stkFull, stkEmpty;
`ifdef PGM_SEQ_STKERR_EN
  logic       stkErr;
`endif

  pgm_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .branch   (branch),
    .call     (call),
    .ret      (ret),
    .pcIn     (pcIn),
    .pcOut    (pcOut),
    .stkDepth (stkDepth),
    .stkFull  (stkFull),
    .stkEmpty (stkEmpty)
`ifdef PGM_SEQ_STKERR_EN
    ,.stkErr  (stkErr)
`endif
  );

  always #5 clk = ~clk;

  int nErr = 0;
  int nChecks = 0;
  bit cmpEn = 1'b0;

  // Reference model state
  int mPc = 0;
  int mStack[$];
  bit mErr = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural rules applied to the model for one clock edge
  task automatic modelEdge(input bit rs, input bit st, input bit br,
                           input bit ca, input bit rt, input int pin);
    if (rs) begin
      mPc = 0;
      mStack.delete();
      mErr = 1'b0;
    end else if (!st) begin
      if (rt) begin
        if (mStack.size() > 0) mPc = mStack.pop_back();
        else begin mPc = (mPc + 1) % 256; mErr = 1'b1; end
      end else if (ca) begin
        if (mStack.size() < 4) begin
          mStack.push_back((mPc + 1) % 256);
          mPc = pin;
        end else begin
          mPc = (mPc + 1) % 256; mErr = 1'b1;
        end
      end else if (br) begin
        mPc = pin;
      end else begin
        mPc = (mPc + 1) % 256;
      end
    end
  endtask

  task automatic step(input bit rs, input bit st, input bit br,
                      input bit ca, input bit rt, input logic [7:0] pin);
    reset = rs; stall = st; branch = br; call = ca; ret = rt; pcIn = pin;
    @(posedge clk);
    modelEdge(rs, st, br, ca, rt, int'(pin));
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 8'h00);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmpEn) begin
      #1;
      chk("pcOut", int'(pcOut), mPc);
      chk("stkDepth", int'(stkDepth), mStack.size());
      chk("stkFull", int'(stkFull), int'(mStack.size() == 4));
      chk("stkEmpty", int'(stkEmpty), int'(mStack.size() == 0));
`ifdef PGM_SEQ_STKERR_EN
      chk("stkErr", int'(stkErr), int'(mErr));
`endif
    end
  end

  initial begin
    #1;
    chk("powerup_pc", int'(pcOut), 0);
    @(negedge clk);

    // Reset then three idle cycles
    step(1, 0, 0, 0, 0, 8'h00);
    cmpEn = 1'b1;
    chk("rst_pc", int'(pcOut), 8'h00);
    chk("rst_empty", int'(stkEmpty), 1);
    chk("rst_full", int'(stkFull), 0);
    idle(); chk("idle1", int'(pcOut), 8'h01);
    idle(); chk("idle2", int'(pcOut), 8'h02);
    idle(); chk("idle3", int'(pcOut), 8'h03);

    // Single call/ret
    idle(); idle(); chk("at5", int'(pcOut), 8'h05);
    step(0, 0, 0, 1, 0, 8'h40);
    chk("call_pc", int'(pcOut), 8'h40); chk("call_depth", int'(stkDepth), 1);
    idle(); chk("c41", int'(pcOut), 8'h41);
    idle(); chk("c42", int'(pcOut), 8'h42);
    step(0, 0, 0, 0, 1, 8'h00);
    chk("ret_pc", int'(pcOut), 8'h06); chk("ret_depth", int'(stkDepth), 0);

    // Nested calls, overflow, unwinding
    step(0, 0, 0, 1, 0, 8'h10);
    step(0, 0, 0, 1, 0, 8'h20);
    step(0, 0, 0, 1, 0, 8'h30);
    step(0, 0, 0, 1, 0, 8'h40);
    chk("nest_full", int'(stkFull), 1);
    step(0, 0, 0, 1, 0, 8'h50);
    chk("ovf_pc", int'(pcOut), 8'h41);
    chk("ovf_depth", int'(stkDepth), 4);
`ifdef PGM_SEQ_STKERR_EN
    chk("ovf_err", int'(stkErr), 1);
`endif
    step(0, 0, 0, 0, 1, 8'h00); chk("ret31", int'(pcOut), 8'h31);
    step(0, 0, 0, 0, 1, 8'h00); chk("ret21", int'(pcOut), 8'h21);
    step(0, 0, 0, 0, 1, 8'h00); chk("ret11", int'(pcOut), 8'h11);
    step(0, 0, 0, 0, 1, 8'h00); chk("ret07", int'(pcOut), 8'h07);

    // Underflow
    step(0, 0, 0, 0, 1, 8'h00);
    chk("unf_pc", int'(pcOut), 8'h08); chk("unf_depth", int'(stkDepth), 0);
    idle();
`ifdef PGM_SEQ_STKERR_EN
    chk("err_sticky", int'(stkErr), 1);
`endif

    // Wrap and stall
    step(0, 0, 1, 0, 0, 8'hFF); chk("br_ff", int'(pcOut), 8'hFF);
    idle(); chk("wrap", int'(pcOut), 8'h00);
    step(0, 1, 1, 0, 0, 8'h33); chk("stall1", int'(pcOut), 8'h00);
    step(0, 1, 1, 0, 0, 8'h33); chk("stall2", int'(pcOut), 8'h00);
    idle(); chk("post_stall", int'(pcOut), 8'h01);

    // Ret beats call; reset mid-chain
    step(0, 0, 1, 0, 0, 8'h21);
    step(0, 0, 0, 1, 0, 8'h60);
    step(0, 0, 0, 1, 1, 8'h70);
    chk("retcall_pc", int'(pcOut), 8'h22); chk("retcall_depth", int'(stkDepth), 0);
    step(0, 0, 0, 1, 0, 8'h01);
    step(0, 0, 0, 1, 0, 8'h02);
    step(0, 0, 0, 1, 0, 8'h03);
    chk("d3", int'(stkDepth), 3);
    step(1, 1, 0, 1, 1, 8'h44);
    chk("midrst_pc", int'(pcOut), 8'h00); chk("midrst_depth", int'(stkDepth), 0);
`ifdef PGM_SEQ_STKERR_EN
    chk("rst_err", int'(stkErr), 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 64) == 0, ($urandom % 6) == 0, ($urandom % 4) == 0,
           ($urandom % 3) == 0, ($urandom % 4) == 0, 8'($urandom));
    end

    cmpEn = 1'b0;
    #2;
    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pgm_sequencer.md
PGM_SEQUENCER -- requirements
Module: pgm_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: program-address width in bits.
REQ-002 Parameter STACK_DEPTH, default 4: number of return-address stack entries; SHALL be a power of two, ≥2.
REQ-003 Parameter RESET_ADDR, default 0: address loaded into pcOut on reset.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hold; freezes all state while high.
REQ-007 branch  input  1  load pcIn into PC.
REQ-008 call  input  1  push return address, then load pcIn into PC.
REQ-009 ret  input  1  pop top of stack into PC.
REQ-010 pcIn  input  ADDR_W  branch/call target.
REQ-011 pcOut  output  ADDR_W  current program address (registered).
REQ-012 stkDepth  output  log2(STACK_DEPTH)+1  number of occupied stack entries.
REQ-013 stkFull  output  1  high when stkDepth == STACK_DEPTH.
REQ-014 stkEmpty  output  1  high when stkDepth == 0.

Function
REQ-015 Per-cycle priority SHALL be: reset > stall > ret > call > branch > increment.
REQ-016 Increment: pcOut <= pcOut+1 modulo 2^ADDR_W; ADDR_W ones wraps to 0, no flag.
REQ-017 Branch: pcOut <= pcIn on the next edge; stack unchanged.
REQ-018 Call when not full: stack[stkDepth] <= pcOut+1 (mod 2^ADDR_W), stkDepth+1, pcOut <= pcIn, all on the same edge.
REQ-019 Call when full: no push, no jump; pcOut increments; stack and stkDepth unchanged.
REQ-020 Ret when not empty: pcOut <= stack[stkDepth-1], stkDepth-1, on the same edge.
REQ-021 Ret when empty: no pop; pcOut increments.
REQ-022 Simultaneous ret and call/branch: ret SHALL win; call/branch ignored for that cycle.
REQ-023 Stall high: pcOut, stack contents and stkDepth SHALL hold; branch/call/ret that cycle are discarded, not deferred.
REQ-024 Latency: every control input takes effect on pcOut exactly one clock after the sampling edge; no combinational path from inputs to pcOut.
REQ-025 stkFull and stkEmpty SHALL be decoded combinationally from registered stkDepth only.

Reset
REQ-026 Reset high at an edge: pcOut <= RESET_ADDR, stkDepth <= 0, stkEmpty=1, stkFull=0, regardless of stall/branch/call/ret.
REQ-027 Reset mid-call-chain SHALL discard all stack entries; stack RAM contents need not be cleared.
REQ-028 Between power-up and the first reset, pcOut SHALL be RESET_ADDR (register initial value).

Configuration
REQ-029 Macro PGM_SEQ_STKERR_EN, when defined, SHALL add output stkErr (1 bit, sticky): set on the edge that samples call-when-full or ret-when-empty (not stalled), cleared only by reset.
REQ-030 Without PGM_SEQ_STKERR_EN the stkErr port SHALL not exist; REQ-019/REQ-021 behaviour is unchanged.

Verification (ADDR_W=8, STACK_DEPTH=4, RESET_ADDR=0)
REQ-031 Reset then 3 idle cycles -> pcOut 00,01,02,03; stkEmpty=1.
REQ-032 At pcOut=05 call pcIn=40, then 2 idle, then ret -> pcOut 40,41,42,06; stkDepth 1,1,1,0.
REQ-033 Four nested calls to 10,20,30,40 then fifth call pcIn=50 at pcOut=40 -> pcOut=41, stkFull=1, stkDepth=4, stkErr=1 (macro on); four rets return 41→... 31,21,11, then original+1.
REQ-034 Ret at stkEmpty with pcOut=07 -> pcOut=08, stkDepth=0, stkErr=1 (macro on); stkErr stays 1 until reset.
REQ-035 pcOut=FF idle -> 00; stall high with branch pcIn=33 for 2 cycles -> pcOut held; stall low -> increment, no branch to 33.
REQ-036 Ret and call same cycle with stkDepth=1 top=22 -> pcOut=22, stkDepth=0; reset asserted with stkDepth=3 -> pcOut=00, stkDepth=0 next edge.
